ram_ctrl: RTL

Control stage that fills a 256x8 single-port RAM IP with a ramp pattern and then reads it back cyclically at a human-visible rate. It drives the RAM's address, write-enable and read-enable. It converts each read word into the display bus (data/point/sign/seg_en) consumed directly by the six-digit dynamic seven-segment driver. Command inputs are single-cycle pulses from the debounced key stage.

---
 rtl/ram_ctrl_if.sv | 24 ++
 rtl/ram_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ram_ctrl_if.sv
// Bundle between ram_ctrl and its neighbours: key pulses in, RAM port out, display bus out.
interface ram_ctrl_if;
    logic        wr_flag;
    logic        rd_flag;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  addr;
    logic [7:0]  wr_data;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;

    modport master (
        input  wr_flag, rd_flag, rd_data,
        output wr_en, rd_en, addr, wr_data, data, point, sign, seg_en
    );

    modport slave (
        output wr_flag, rd_flag, rd_data,
        input  wr_en, rd_en, addr, wr_data, data, point, sign, seg_en
    );
endinterface

// File: rtl/ram_ctrl.sv
// Fills a 256x8 RAM with a ramp, then cycles through it at a visible rate and
// forwards each read byte to the six-digit seven-segment display bus.
// state | meaning
// IDLE  | no RAM access, address held
// WRITE | one write per cycle, wr_data = addr, 0..ADDR_MAX
// READ  | rd_en held, address advances every CNT_MAX+1 cycles
module ram_ctrl #(
    parameter logic [23:0] CNT_MAX  = 24'd9_999_999,
    parameter logic [7:0]  ADDR_MAX = 8'd255
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    ram_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_addr;
    logic [7:0]  w_addr_nxt;
    logic [7:0]  r_wr_data;
    logic [7:0]  w_wr_data_nxt;
    logic        r_wr_en;
    logic        w_wr_en_nxt;
    logic        r_rd_en;
    logic        w_rd_en_nxt;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic        r_rd_en_d1;
    logic [7:0]  r_data;
    logic        r_seg_en;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write pulse outranks read pulse everywhere it is honoured.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_wr_data_nxt = 8'd0;
        w_cnt_nxt     = 24'd0;
        case (r_state)
            IDLE: begin
                if (bus.wr_flag) begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = 8'd0;
                    w_wr_en_nxt = 1'b1;
                end else if (bus.rd_flag) begin
                    w_state_nxt = READ;
                    w_addr_nxt  = 8'd0;
                    w_rd_en_nxt = 1'b1;
                end
            end
            WRITE: begin
                if (r_addr == ADDR_MAX) begin
                    w_state_nxt = IDLE;
                    w_addr_nxt  = 8'd0;
                end else begin
                    w_addr_nxt    = r_addr + 8'd1;
                    w_wr_data_nxt = r_addr + 8'd1;
                    w_wr_en_nxt   = 1'b1;
                end
            end
            READ: begin
                if (bus.wr_flag) begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = 8'd0;
                    w_wr_en_nxt = 1'b1;
                end else if (bus.rd_flag) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_rd_en_nxt = 1'b1;
                    if (r_cnt == CNT_MAX) begin
                        w_addr_nxt = (r_addr == ADDR_MAX) ? 8'd0 : r_addr + 8'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 24'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_addr_nxt  = 8'd0;
            end
        endcase
    end

    // RAM read latency is one cycle, so capture follows rd_en by one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_addr     <= 8'd0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wr_data  <= 8'd0;
            r_cnt      <= 24'd0;
            r_rd_en_d1 <= 1'b0;
            r_data     <= 8'd0;
            r_seg_en   <= 1'b0;
        end else begin
            r_addr     <= w_addr_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_en_d1 <= r_rd_en;
            if (r_rd_en_d1) begin
                r_data   <= bus.rd_data;
                r_seg_en <= 1'b1;
            end
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.rd_en   = r_rd_en;
    assign bus.addr    = r_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.data    = {12'd0, r_data};
    assign bus.point   = 6'b000000;
    assign bus.sign    = 1'b0;
    assign bus.seg_en  = r_seg_en;

endmodule
